// File: rtl/br_redirect_ctrl.sv
// EX-stage branch resolution: mispredict detection, pipeline flush, held fetch
// redirect, predictor-update FIFO and branch/mispredict performance counters.
module br_redirect_ctrl #(
  parameter int UPD_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ex_valid,
  input  logic        ex_stall,
  input  logic [3:0]  ex_br_type,
  input  logic [31:0] ex_pc,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  input  logic        br,
  input  logic [31:0] pc_br,
  input  logic        fetch_ready,
  input  logic        upd_ready,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        upd_valid,
  output logic [31:0] upd_pc,
  output logic [31:0] upd_target,
  output logic        upd_taken,
  output logic        upd_mis,
  output logic [31:0] perf_br_cnt,
  output logic [31:0] perf_mis_cnt,
  output logic [31:0] perf_upd_drop
);

  localparam int AW = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(UPD_DEPTH);
  localparam logic [AW:0] ZERO_CNT_C = {(AW + 1){1'b0}};
  localparam logic [AW-1:0] ONE_PTR_C = AW'(1'b1);
  localparam logic [AW-1:0] ZERO_PTR_C = {AW{1'b0}};

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] REDIRECT = 1'b1;

  function automatic logic is_branch(input logic [3:0] br_type);
    case (br_type)
      4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
      4'b1000, 4'b1001, 4'b1010, 4'b1011: is_branch = 1'b1;
      default:                            is_branch = 1'b0;
    endcase
  endfunction

  logic [0:0]    state_r;
  logic          redirect_valid_r;
  logic [31:0]   redirect_pc_r;
  logic [31:0]   br_cnt_r;
  logic [31:0]   mis_cnt_r;
  logic [31:0]   drop_cnt_r;
  logic [65:0]   mem_r [UPD_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   cnt_r;

  logic          fire_s;
  logic          mis_s;
  logic [31:0]   correct_pc_s;
  logic          full_s;
  logic          deq_s;
  logic          accept_s;
  logic          drop_s;
  logic [65:0]   head_s;

  // Resolution only happens while idle; branches seen during a redirect are ignored.
  always_comb begin
    fire_s       = ex_valid & ~ex_stall & is_branch(ex_br_type) & (state_r == IDLE);
    mis_s        = fire_s & ((br != ex_pred_taken) | (br & (pc_br != ex_pred_target)));
    correct_pc_s = br ? pc_br : (ex_pc + 32'd4);
  end

  // FIFO handshake: a full FIFO still accepts when its head leaves in the same cycle.
  always_comb begin
    full_s   = (cnt_r == DEPTH_C);
    deq_s    = upd_valid & upd_ready;
    accept_s = fire_s & (~full_s | deq_s);
    drop_s   = fire_s & full_s & ~deq_s;
    head_s   = mem_r[rd_ptr_r];
  end

  // Redirect state machine: hold the corrected PC until fetch accepts it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r          <= IDLE;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (mis_s) begin
            state_r          <= REDIRECT;
            redirect_valid_r <= 1'b1;
            redirect_pc_r    <= correct_pc_s;
          end else begin
            state_r          <= IDLE;
          end
        end
        REDIRECT: begin
          if (fetch_ready) begin
            state_r          <= IDLE;
            redirect_valid_r <= 1'b0;
          end else begin
            state_r          <= REDIRECT;
          end
        end
        default: begin
          state_r          <= IDLE;
          redirect_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_r <= ZERO_PTR_C;
      rd_ptr_r <= ZERO_PTR_C;
      cnt_r    <= ZERO_CNT_C;
    end else begin
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_PTR_C;
      end
      if (deq_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_PTR_C;
      end
      case ({accept_s, deq_s})
        2'b10:   cnt_r <= cnt_r + (AW + 1)'(1'b1);
        2'b01:   cnt_r <= cnt_r - (AW + 1)'(1'b1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // FIFO storage; contents are only observable while occupancy is non-zero.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_r[wr_ptr_r] <= {ex_pc, pc_br, br, mis_s};
    end
  end

  // Performance counters, free-running modulo 2^32.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      br_cnt_r   <= 32'd0;
      mis_cnt_r  <= 32'd0;
      drop_cnt_r <= 32'd0;
    end else begin
      if (fire_s) begin
        br_cnt_r <= br_cnt_r + 32'd1;
      end
      if (mis_s) begin
        mis_cnt_r <= mis_cnt_r + 32'd1;
      end
      if (drop_s) begin
        drop_cnt_r <= drop_cnt_r + 32'd1;
      end
    end
  end

  // Flushes cover the mispredict cycle and every cycle the redirect is pending.
  assign flush_if_id    = mis_s | (state_r == REDIRECT);
  assign flush_id_ex    = mis_s | (state_r == REDIRECT);
  assign redirect_valid = redirect_valid_r;
  assign redirect_pc    = redirect_pc_r;

  assign upd_valid  = (cnt_r != ZERO_CNT_C);
  assign upd_pc     = upd_valid ? head_s[65:34] : 32'd0;
  assign upd_target = upd_valid ? head_s[33:2]  : 32'd0;
  assign upd_taken  = upd_valid ? head_s[1]     : 1'b0;
  assign upd_mis    = upd_valid ? head_s[0]     : 1'b0;

  assign perf_br_cnt   = br_cnt_r;
  assign perf_mis_cnt  = mis_cnt_r;
  assign perf_upd_drop = drop_cnt_r;

endmodule

// File: tb/tb_br_redirect_ctrl.sv
// Directed bench for br_redirect_ctrl; update records and accepted redirects are
// checked by a scoreboard monitor, flushes and counters by direct checks.
module tb_br_redirect_ctrl;

  logic        clk;
  logic        rstn;
  logic        ex_valid;
  logic        ex_stall;
  logic [3:0]  ex_br_type;
  logic [31:0] ex_pc;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        br;
  logic [31:0] pc_br;
  logic        fetch_ready;
  logic        upd_ready;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        upd_mis;
  logic [31:0] perf_br_cnt;
  logic [31:0] perf_mis_cnt;
  logic [31:0] perf_upd_drop;

  int total;
  int bad;
  logic started;
  logic [65:0] exp_upd_q [$];
  logic [31:0] exp_redir_q [$];

  br_redirect_ctrl #(.UPD_DEPTH(2)) dut (
    .clk(clk), .rstn(rstn), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .ex_br_type(ex_br_type), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .br(br), .pc_br(pc_br),
    .fetch_ready(fetch_ready), .upd_ready(upd_ready),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_mis(upd_mis),
    .perf_br_cnt(perf_br_cnt), .perf_mis_cnt(perf_mis_cnt),
    .perf_upd_drop(perf_upd_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: handshakes are stable at the falling edge before the accepting edge.
  always @(negedge clk) begin
    if (started && rstn && upd_valid && upd_ready) begin
      total++;
      if (exp_upd_q.size() == 0) begin
        bad++;
        $display("FAIL upd_unexpected: got pc=%h tgt=%h t=%b m=%b expected none",
                 upd_pc, upd_target, upd_taken, upd_mis);
      end else begin
        logic [65:0] e;
        e = exp_upd_q.pop_front();
        if ({upd_pc, upd_target, upd_taken, upd_mis} !== e) begin
          bad++;
          $display("FAIL upd_record: got pc=%h tgt=%h t=%b m=%b expected pc=%h tgt=%h t=%b m=%b",
                   upd_pc, upd_target, upd_taken, upd_mis, e[65:34], e[33:2], e[1], e[0]);
        end
      end
    end
    if (started && rstn && redirect_valid && fetch_ready) begin
      total++;
      if (exp_redir_q.size() == 0) begin
        bad++;
        $display("FAIL redir_unexpected: got %h expected none", redirect_pc);
      end else begin
        logic [31:0] r;
        r = exp_redir_q.pop_front();
        if (redirect_pc !== r) begin
          bad++;
          $display("FAIL redir_pc: got %h expected %h", redirect_pc, r);
        end
      end
    end
  end

  task automatic drive(input logic [3:0] t, input logic [31:0] pc, input logic pt,
                       input logic [31:0] ptgt, input logic b, input logic [31:0] tgt);
    ex_valid = 1'b1; ex_stall = 1'b0; ex_br_type = t; ex_pc = pc;
    ex_pred_taken = pt; ex_pred_target = ptgt; br = b; pc_br = tgt;
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_stall = 1'b0; ex_br_type = 4'b0000; br = 1'b0;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flush(input string name, input logic exp);
    chk({name, "_if_id"}, {31'd0, flush_if_id}, {31'd0, exp});
    chk({name, "_id_ex"}, {31'd0, flush_id_ex}, {31'd0, exp});
  endtask

  initial begin
    total = 0; bad = 0; started = 1'b0;
    rstn = 1'b0; fetch_ready = 1'b1; upd_ready = 1'b1;
    ex_pc = 32'd0; ex_pred_taken = 1'b0; ex_pred_target = 32'd0; pc_br = 32'd0;
    idle();
    to_next(); to_next();
    rstn = 1'b1; started = 1'b1;
    to_neg();
    chk("rst_redir_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_redir_pc", redirect_pc, 32'd0);
    chk("rst_upd_valid", {31'd0, upd_valid}, 32'd0);
    chk("rst_br_cnt", perf_br_cnt, 32'd0);
    chk_flush("rst_flush", 1'b0);
    to_next();

    // Mispredicted BEQ: predicted not taken, actually taken.
    drive(4'b0110, 32'h1C00_0100, 1'b0, 32'h0, 1'b1, 32'h1C00_0200);
    exp_upd_q.push_back({32'h1C00_0100, 32'h1C00_0200, 1'b1, 1'b1});
    exp_redir_q.push_back(32'h1C00_0200);
    to_neg();
    chk_flush("beq_flush_t", 1'b1);
    chk("beq_redir_t", {31'd0, redirect_valid}, 32'd0);
    to_next(); idle(); to_neg();
    chk_flush("beq_flush_t1", 1'b1);
    chk("beq_redir_t1", {31'd0, redirect_valid}, 32'd1);
    chk("beq_mis_cnt", perf_mis_cnt, 32'd1);
    to_next(); to_neg();
    chk_flush("beq_flush_t2", 1'b0);
    chk("beq_redir_t2", {31'd0, redirect_valid}, 32'd0);
    to_next();

    // BNE at top of address space, predicted taken but not taken: PC wraps.
    drive(4'b0111, 32'hFFFF_FFFC, 1'b1, 32'h0000_0100, 1'b0, 32'h1234_5678);
    exp_upd_q.push_back({32'hFFFF_FFFC, 32'h1234_5678, 1'b0, 1'b1});
    exp_redir_q.push_back(32'h0000_0000);
    to_next(); idle(); to_neg();
    chk("bne_upd_taken", {31'd0, upd_taken}, 32'd0);
    chk("bne_upd_mis", {31'd0, upd_mis}, 32'd1);
    chk("bne_mis_cnt", perf_mis_cnt, 32'd2);
    to_next();

    // JIRL with wrong target.
    drive(4'b0011, 32'h1C00_0300, 1'b1, 32'h0000_1000, 1'b1, 32'h0000_2000);
    exp_upd_q.push_back({32'h1C00_0300, 32'h0000_2000, 1'b1, 1'b1});
    exp_redir_q.push_back(32'h0000_2000);
    to_next(); idle(); to_neg();
    chk("jirl_redir_pc", redirect_pc, 32'h0000_2000);
    chk("jirl_mis_cnt", perf_mis_cnt, 32'd3);
    to_next();

    // Fetch stalls a redirect for five cycles; a branch in EX meanwhile is ignored.
    fetch_ready = 1'b0;
    drive(4'b0100, 32'h1C00_0400, 1'b0, 32'h0, 1'b1, 32'h1C00_0800);
    exp_upd_q.push_back({32'h1C00_0400, 32'h1C00_0800, 1'b1, 1'b1});
    exp_redir_q.push_back(32'h1C00_0800);
    to_next(); idle();
    for (int i = 0; i < 5; i++) begin
      if (i == 1) drive(4'b0101, 32'h1C00_0500, 1'b0, 32'h0, 1'b1, 32'h1C00_0900);
      else idle();
      to_neg();
      chk("hold_redir_valid", {31'd0, redirect_valid}, 32'd1);
      chk("hold_redir_pc", redirect_pc, 32'h1C00_0800);
      chk_flush("hold_flush", 1'b1);
      to_next();
    end
    idle();
    chk("hold_br_cnt", perf_br_cnt, 32'd4);
    chk("hold_mis_cnt", perf_mis_cnt, 32'd4);
    chk("hold_upd_valid", {31'd0, upd_valid}, 32'd0);
    fetch_ready = 1'b1;
    to_next(); to_neg();
    chk("hold_release", {31'd0, redirect_valid}, 32'd0);
    chk_flush("hold_release_flush", 1'b0);
    to_next();

    // Non-branch encoding and a stalled branch must not fire.
    drive(4'b1100, 32'h1C00_0600, 1'b0, 32'h0, 1'b1, 32'h1C00_0700);
    to_neg(); chk_flush("nonbr_flush", 1'b0); to_next();
    drive(4'b0110, 32'h1C00_0600, 1'b0, 32'h0, 1'b1, 32'h1C00_0700);
    ex_stall = 1'b1;
    to_neg(); chk_flush("stall_flush", 1'b0); to_next();
    idle(); to_neg();
    chk("nofire_br_cnt", perf_br_cnt, 32'd4);
    to_next();

    // FIFO overflow: three correct branches with the predictor stalled.
    upd_ready = 1'b0;
    drive(4'b1000, 32'h1C00_1000, 1'b0, 32'h0, 1'b0, 32'h1C00_1100);
    exp_upd_q.push_back({32'h1C00_1000, 32'h1C00_1100, 1'b0, 1'b0});
    to_neg(); chk_flush("ok1_flush", 1'b0); to_next();
    drive(4'b1001, 32'h1C00_1004, 1'b1, 32'h1C00_2000, 1'b1, 32'h1C00_2000);
    exp_upd_q.push_back({32'h1C00_1004, 32'h1C00_2000, 1'b1, 1'b0});
    to_neg(); chk_flush("ok2_flush", 1'b0); to_next();
    drive(4'b1011, 32'h1C00_1008, 1'b0, 32'h0, 1'b0, 32'h1C00_3300);
    to_neg(); chk_flush("ok3_flush", 1'b0); to_next();
    idle(); to_neg();
    chk("ovf_drop", perf_upd_drop, 32'd1);
    chk("ovf_br_cnt", perf_br_cnt, 32'd7);
    chk("ovf_head_pc", upd_pc, 32'h1C00_1000);
    chk("ovf_redir", {31'd0, redirect_valid}, 32'd0);
    to_next();
    upd_ready = 1'b1;
    drive(4'b0101, 32'h1C00_100C, 1'b1, 32'h1C00_3000, 1'b1, 32'h1C00_3000);
    exp_upd_q.push_back({32'h1C00_100C, 32'h1C00_3000, 1'b1, 1'b0});
    to_next(); idle(); to_next(); to_next(); to_neg();
    chk("full_deq_drop", perf_upd_drop, 32'd1);
    chk("full_deq_br_cnt", perf_br_cnt, 32'd8);
    chk("full_deq_empty", {31'd0, upd_valid}, 32'd0);
    to_next();

    // Reset in the middle of a pending redirect with a record held in the FIFO.
    fetch_ready = 1'b0; upd_ready = 1'b0;
    drive(4'b1010, 32'h1C00_2000, 1'b1, 32'h1C00_2400, 1'b1, 32'h1C00_2800);
    to_next(); idle(); to_neg();
    chk("rr_redir_pc", redirect_pc, 32'h1C00_2800);
    chk("rr_upd_valid", {31'd0, upd_valid}, 32'd1);
    to_next();
    rstn = 1'b0;
    to_next();
    rstn = 1'b1;
    to_neg();
    chk("rr_redir_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rr_redir_pc0", redirect_pc, 32'd0);
    chk("rr_upd_valid0", {31'd0, upd_valid}, 32'd0);
    chk("rr_upd_pc0", upd_pc, 32'd0);
    chk("rr_upd_tgt0", upd_target, 32'd0);
    chk("rr_upd_bits0", {30'd0, upd_taken, upd_mis}, 32'd0);
    chk("rr_br_cnt0", perf_br_cnt, 32'd0);
    chk("rr_mis_cnt0", perf_mis_cnt, 32'd0);
    chk("rr_drop0", perf_upd_drop, 32'd0);
    chk_flush("rr_flush0", 1'b0);
    upd_ready = 1'b1; fetch_ready = 1'b1;
    to_next(); to_next(); to_neg();

    chk("upd_q_drained", exp_upd_q.size(), 32'd0);
    chk("redir_q_drained", exp_redir_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
